// File: rtl/adc_ser_if.sv
`default_nettype none
// ============================================================================
// Module  : adc_ser_if
// Purpose : Serial-pin and sample-side bundle of the ADC serial responder.
// Revision: 1.0  initial release
// ============================================================================
interface adc_ser_if #(
    parameter int DATA_W = 16
);
    logic              sck_in;
    logic              cs_n_in;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sdo;
    logic              sdo_oe;
    logic              busy;
    logic              frame_done;
    logic              frame_abort;
    logic              stale;
    logic              overrun;

    modport master (
        output sck_in, cs_n_in, sample_data, sample_valid,
        input  sdo, sdo_oe, busy, frame_done, frame_abort, stale, overrun
    );

    modport slave (
        input  sck_in, cs_n_in, sample_data, sample_valid,
        output sdo, sdo_oe, busy, frame_done, frame_abort, stale, overrun
    );
endinterface
`default_nettype wire

// File: rtl/adc_ser_responder.sv
`default_nettype none
// ============================================================================
// Module  : adc_ser_responder
// Purpose : Serves a held parallel sample MSB-first on an asynchronous
//           serial clock/select pair, with stale/abort/overrun reporting.
// Revision: 1.0  initial release
// ============================================================================
module adc_ser_responder #(
    parameter int DATA_W   = 16,
    parameter int SYNC_STG = 2
) (
    input  logic      clk_100,
    input  logic      reset,
    adc_ser_if.slave  bus
);
    localparam int                c_CNT_W = $clog2(DATA_W) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SYNC_STG:0]   r_sck_sync;
    logic [SYNC_STG:0]   r_cs_sync;
    logic [DATA_W-1:0]   r_hold, w_hold_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [c_CNT_W-1:0]  r_bit_cnt, w_cnt_nxt;
    logic                r_fresh, w_fresh_nxt;
    logic                r_sdo, w_sdo_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_stale, w_stale_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                r_done, w_done_nxt;
    logic                r_abort, w_abort_nxt;
    logic                w_sck_fall;
    logic                w_cs_fall;
    logic                w_cs_rise;

    // Top bit of each chain is the history flop; edges compare it with the
    // last synchronizer stage so detection latency is fixed.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STG-1:0], bus.sck_in};
            r_cs_sync  <= {r_cs_sync[SYNC_STG-1:0],  bus.cs_n_in};
        end
    end

    assign w_sck_fall = r_sck_sync[SYNC_STG]  & ~r_sck_sync[SYNC_STG-1];
    assign w_cs_fall  = r_cs_sync[SYNC_STG]   & ~r_cs_sync[SYNC_STG-1];
    assign w_cs_rise  = ~r_cs_sync[SYNC_STG]  &  r_cs_sync[SYNC_STG-1];

    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_fresh   <= 1'b0;
            r_sdo     <= 1'b0;
            r_busy    <= 1'b0;
            r_stale   <= 1'b0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_fresh   <= w_fresh_nxt;
            r_sdo     <= w_sdo_nxt;
            r_busy    <= w_busy_nxt;
            r_stale   <= w_stale_nxt;
            r_overrun <= w_overrun_nxt;
            r_done    <= w_done_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_bit_cnt;
        w_fresh_nxt   = r_fresh;
        w_sdo_nxt     = r_sdo;
        w_busy_nxt    = r_busy;
        w_stale_nxt   = r_stale;
        w_overrun_nxt = r_overrun;
        w_done_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_sdo_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_sdo_nxt   = 1'b0;
                    w_stale_nxt = 1'b0;
                end else begin
                    w_shift_nxt = r_hold;
                    w_stale_nxt = ~r_fresh;
                    w_fresh_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_sdo_nxt   = r_hold[DATA_W-1];
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Select release outranks a coincident shift edge.
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_sdo_nxt   = 1'b0;
                    w_stale_nxt = 1'b0;
                end else if (w_sck_fall) begin
                    w_cnt_nxt   = r_bit_cnt + c_CNT_W'(1);
                    w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                    if (r_bit_cnt == c_LAST) begin
                        w_state_nxt = TAIL;
                        w_sdo_nxt   = 1'b0;
                    end else begin
                        w_sdo_nxt   = r_shift[DATA_W-2];
                    end
                end
            end
            TAIL: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_sdo_nxt   = 1'b0;
                    w_stale_nxt = 1'b0;
                end else if (w_sck_fall) begin
                    w_sdo_nxt     = 1'b0;
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sdo_nxt   = 1'b0;
            end
        endcase

        // A new sample always lands in the holding register, even mid-LOAD,
        // and stays marked fresh until a frame actually picks it up.
        if (bus.sample_valid) begin
            w_hold_nxt  = bus.sample_data;
            w_fresh_nxt = 1'b1;
        end
    end

    assign bus.sdo         = r_sdo;
    assign bus.sdo_oe      = (r_state != IDLE);
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_done;
    assign bus.frame_abort = r_abort;
    assign bus.stale       = r_stale;
    assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_ser_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_ser_responder
// Purpose : Directed self-checking bench acting as serial master (8-cycle
//           sck phases) against adc_ser_responder.
// Revision: 1.0  initial release
// ============================================================================
module tb_adc_ser_responder;
    logic clk_100 = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt  = 0;
    int   abort_cnt = 0;

    adc_ser_if #(.DATA_W(16)) bus ();

    adc_ser_responder #(.DATA_W(16), .SYNC_STG(2)) dut (
        .clk_100 (clk_100),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    always @(negedge clk_100) begin
        if (bus.frame_done)  done_cnt  = done_cnt + 1;
        if (bus.frame_abort) abort_cnt = abort_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic load_sample(input logic [15:0] d);
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        wait_neg(1);
        bus.sample_valid = 1'b0;
        wait_neg(1);
    endtask

    task automatic frame_start();
        bus.cs_n_in = 1'b0;
        wait_neg(8);
    endtask

    // Master samples sdo just before each rising sck edge.
    task automatic frame_bits(input int n, output logic [31:0] rd,
                              output logic st, output logic act);
        rd  = '0;
        st  = 1'b0;
        act = 1'b0;
        for (int i = 0; i < n; i++) begin
            rd = {rd[30:0], bus.sdo};
            if (i == 0) begin
                st  = bus.stale;
                act = bus.busy & bus.sdo_oe;
            end
            bus.sck_in = 1'b1;
            wait_neg(8);
            bus.sck_in = 1'b0;
            wait_neg(8);
        end
    endtask

    task automatic frame_end();
        bus.cs_n_in = 1'b1;
        wait_neg(8);
    endtask

    task automatic test_reset();
        logic [6:0] v;
        reset = 1'b1;
        wait_neg(4);
        v = {bus.sdo, bus.sdo_oe, bus.busy, bus.frame_done,
             bus.frame_abort, bus.stale, bus.overrun};
        n_checks++;
        if (v !== 7'b0) $display("FAIL reset_outputs: got %b want %b", v, 7'b0);
        else n_pass++;
        reset = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_latency();
        int a0;
        load_sample(16'h8000);
        a0 = abort_cnt;
        frame_start();
        n_checks++;
        if (bus.sdo !== 1'b1) $display("FAIL lat_msb: got %b want 1", bus.sdo);
        else n_pass++;
        bus.sck_in = 1'b1;
        wait_neg(8);
        bus.sck_in = 1'b0;
        wait_neg(2);
        n_checks++;
        if (bus.sdo !== 1'b1) $display("FAIL lat_early: got %b want 1", bus.sdo);
        else n_pass++;
        wait_neg(1);
        n_checks++;
        if (bus.sdo !== 1'b0) $display("FAIL lat_exact: got %b want 0", bus.sdo);
        else n_pass++;
        wait_neg(5);
        frame_end();
        n_checks++;
        if (abort_cnt - a0 !== 1) $display("FAIL lat_abort: got %0d want 1", abort_cnt - a0);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic st, act;
        int d0;
        load_sample(16'hA5C3);
        d0 = done_cnt;
        frame_start();
        frame_bits(16, rd, st, act);
        frame_end();
        n_checks++;
        if (rd[15:0] !== 16'hA5C3) $display("FAIL basic_data: got %h want a5c3", rd[15:0]);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL basic_done: got %0d want 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if ({st, act} !== 2'b01) $display("FAIL basic_stale_busy: got %b want 01", {st, act});
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.sdo_oe, bus.sdo} !== 3'b000)
            $display("FAIL basic_idle: got %b want 000", {bus.busy, bus.sdo_oe, bus.sdo});
        else n_pass++;
    endtask

    task automatic test_stale_repeat();
        logic [31:0] rd;
        logic st, act;
        frame_start();
        frame_bits(16, rd, st, act);
        frame_end();
        n_checks++;
        if (rd[15:0] !== 16'hA5C3) $display("FAIL repeat_data: got %h want a5c3", rd[15:0]);
        else n_pass++;
        n_checks++;
        if (st !== 1'b1) $display("FAIL repeat_stale: got %b want 1", st);
        else n_pass++;
        n_checks++;
        if (bus.stale !== 1'b0) $display("FAIL repeat_stale_clr: got %b want 0", bus.stale);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic st, act;
        int a0, d0;
        a0 = abort_cnt;
        d0 = done_cnt;
        frame_start();
        frame_bits(7, rd, st, act);
        frame_end();
        n_checks++;
        if ({abort_cnt - a0, done_cnt - d0} !== {32'd1, 32'd0})
            $display("FAIL abort_pulses: got abort=%0d done=%0d want 1/0", abort_cnt - a0, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (rd[6:0] !== 7'b1010010) $display("FAIL abort_partial: got %b want 1010010", rd[6:0]);
        else n_pass++;
        load_sample(16'h1234);
        frame_start();
        frame_bits(16, rd, st, act);
        frame_end();
        n_checks++;
        if ({rd[15:0], st} !== {16'h1234, 1'b0})
            $display("FAIL abort_next: got %h stale %b want 1234 stale 0", rd[15:0], st);
        else n_pass++;
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        logic st, act;
        load_sample(16'h5A5A);
        n_checks++;
        if (bus.overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", bus.overrun);
        else n_pass++;
        frame_start();
        frame_bits(18, rd, st, act);
        frame_end();
        n_checks++;
        if (rd[17:0] !== 18'h16968) $display("FAIL ovr_data: got %h want 16968", rd[17:0]);
        else n_pass++;
        n_checks++;
        if (bus.overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_load_collision();
        logic [31:0] rd;
        logic st, act;
        bit found;
        load_sample(16'h0001);
        bus.cs_n_in = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            wait_neg(1);
            if (bus.sdo_oe) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL coll_load_seen: got 0 want 1");
        else n_pass++;
        bus.sample_data  = 16'hFFFF;
        bus.sample_valid = 1'b1;
        wait_neg(1);
        bus.sample_valid = 1'b0;
        wait_neg(6);
        frame_bits(16, rd, st, act);
        frame_end();
        n_checks++;
        if ({rd[15:0], st} !== {16'h0001, 1'b0})
            $display("FAIL coll_first: got %h stale %b want 0001 stale 0", rd[15:0], st);
        else n_pass++;
        frame_start();
        frame_bits(16, rd, st, act);
        frame_end();
        n_checks++;
        if ({rd[15:0], st} !== {16'hFFFF, 1'b0})
            $display("FAIL coll_second: got %h stale %b want ffff stale 0", rd[15:0], st);
        else n_pass++;
        n_checks++;
        if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        logic st, act;
        logic [6:0] v;
        int a0, d0;
        frame_start();
        frame_bits(5, rd, st, act);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL rst_mid_busy: got %b want 1", bus.busy);
        else n_pass++;
        a0 = abort_cnt;
        d0 = done_cnt;
        reset = 1'b1;
        wait_neg(1);
        v = {bus.sdo, bus.sdo_oe, bus.busy, bus.frame_done,
             bus.frame_abort, bus.stale, bus.overrun};
        n_checks++;
        if (v !== 7'b0) $display("FAIL rst_mid_outputs: got %b want %b", v, 7'b0);
        else n_pass++;
        bus.cs_n_in = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        wait_neg(6);
        n_checks++;
        if ({abort_cnt - a0, done_cnt - d0} !== {32'd0, 32'd0})
            $display("FAIL rst_mid_pulses: got abort=%0d done=%0d want 0/0", abort_cnt - a0, done_cnt - d0);
        else n_pass++;
        d0 = done_cnt;
        frame_start();
        frame_bits(16, rd, st, act);
        frame_end();
        n_checks++;
        if ({rd[15:0], st} !== {16'h0000, 1'b1})
            $display("FAIL rst_next_frame: got %h stale %b want 0000 stale 1", rd[15:0], st);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL rst_next_done: got %0d want 1", done_cnt - d0);
        else n_pass++;
    endtask

    initial begin
        bus.sck_in       = 1'b0;
        bus.cs_n_in      = 1'b1;
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        test_reset();
        test_latency();
        test_basic();
        test_stale_repeat();
        test_abort();
        test_overrun();
        test_load_collision();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
